// File: rtl/y86_mem_stage_if.sv
// ============================================================================
//  Module      : y86_mem_stage_if
//  Description : Request/response bundle between execute and the Y86-64 memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface y86_mem_stage_if;
    logic        start_i;
    logic [3:0]  icode_i;
    logic [63:0] vala_i;
    logic [63:0] vale_i;
    logic [63:0] valp_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] valm_o;
    logic        dmem_error_o;

    modport master (
        output start_i, icode_i, vala_i, vale_i, valp_i,
        input  busy_o, done_o, valm_o, dmem_error_o
    );

    modport slave (
        input  start_i, icode_i, vala_i, vale_i, valp_i,
        output busy_o, done_o, valm_o, dmem_error_o
    );
endinterface

`default_nettype wire

// File: rtl/y86_mem_stage.sv
// ============================================================================
//  Module      : y86_mem_stage
//  Description : Y86-64 SEQ memory stage; quadword access to a byte-wide,
//                little-endian data memory, one byte per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_mem_stage #(
    parameter int DMEM_BYTES = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    y86_mem_stage_if.slave    bus
);

    localparam int          AW         = $clog2(DMEM_BYTES);
    localparam logic [63:0] C_MAX_ADDR = 64'(DMEM_BYTES - 8);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [55:0]     shadow_q, shadow_d;
    logic [63:0]     valm_q, valm_d;
    logic            err_q, err_d;

    logic [7:0]      mem_q [DMEM_BYTES];

    logic            w_is_read;
    logic            w_is_write;
    logic [63:0]     w_addr;
    logic [63:0]     w_wdata;
    logic            w_fault;
    logic [AW-1:0]   w_byte_addr;
    logic [7:0]      w_rbyte;
    logic [7:0]      w_wbyte;

    always_comb begin
        w_is_read  = 1'b0;
        w_is_write = 1'b0;
        w_addr     = bus.vale_i;
        w_wdata    = bus.vala_i;
        case (bus.icode_i)
            4'h4, 4'hA: w_is_write = 1'b1;
            4'h8: begin
                w_is_write = 1'b1;
                w_wdata    = bus.valp_i;
            end
            4'h5: w_is_read = 1'b1;
            4'h9, 4'hB: begin
                w_is_read = 1'b1;
                w_addr    = bus.vala_i;
            end
            default: ;
        endcase
    end

    // Full 64-bit unsigned compare so huge addresses never alias into the array.
    assign w_fault     = (w_is_read | w_is_write) && (w_addr > C_MAX_ADDR);
    assign w_byte_addr = addr_q + AW'(cnt_q);
    assign w_rbyte     = mem_q[w_byte_addr];
    assign w_wbyte     = wdata_q[{cnt_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            wr_q     <= 1'b0;
            shadow_q <= 56'd0;
            valm_q   <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            shadow_q <= shadow_d;
            valm_q   <= valm_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        shadow_d = shadow_q;
        valm_d   = valm_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    err_d = 1'b0;
                    if (!(w_is_read | w_is_write)) begin
                        state_d = S_DONE;
                        valm_d  = 64'd0;
                    end else if (w_fault) begin
                        state_d = S_DONE;
                        valm_d  = 64'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = 3'd0;
                        addr_d  = w_addr[AW-1:0];
                        wdata_d = w_wdata;
                        wr_d    = w_is_write;
                    end
                end
            end
            S_ACCESS: begin
                // Bytes 0..6 shift in from the top; byte 7 joins them at the DONE transition.
                shadow_d = {w_rbyte, shadow_q[55:8]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                    valm_d  = wr_q ? 64'd0 : {w_rbyte, shadow_q};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is deliberately outside the reset domain: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && wr_q) begin
            mem_q[w_byte_addr] <= w_wbyte;
        end
    end

    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = (state_q == S_DONE);
    assign bus.valm_o       = valm_q;
    assign bus.dmem_error_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_y86_mem_stage.sv
// ============================================================================
//  Module      : tb_y86_mem_stage
//  Description : Self-checking bench for y86_mem_stage (directed table, handshake
//                and reset corner cases, randomized ops against a byte-array model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_mem_stage;

    localparam int DMEM_BYTES = 1024;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [7:0] ref_mem [DMEM_BYTES];

    y86_mem_stage_if bus_if ();

    y86_mem_stage #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [63:0] vala;
        logic [63:0] vale;
        logic [63:0] valp;
        logic [63:0] exp_valm;
        logic        exp_err;
        int          exp_lat;
        logic        chk_valm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [3:0] ic, logic [63:0] a, logic [63:0] e,
                                logic [63:0] p, logic [63:0] m, logic er, int lat, logic cv);
        vec_t v;
        v.name = n; v.icode = ic; v.vala = a; v.vale = e; v.valp = p;
        v.exp_valm = m; v.exp_err = er; v.exp_lat = lat; v.chk_valm = cv;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decode by instruction meaning, then move 8 bytes in a plain array.
    function automatic void model(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                                  input logic [63:0] p, output logic [63:0] m, output logic err,
                                  output int lat, output logic chk);
        logic        rd, wr;
        logic [63:0] addr, data;
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        m = 64'd0; err = 1'b0; lat = 1; chk = !wr;
        if (!rd && !wr) return;
        if (addr > 64'(DMEM_BYTES - 8)) begin
            err = 1'b1;
            chk = 1'b1;
            return;
        end
        lat = 9;
        for (int i = 0; i < 8; i++) begin
            if (wr) ref_mem[int'(addr) + i] = data[8*i +: 8];
            else    m[8*i +: 8] = ref_mem[int'(addr) + i];
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following done.
    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, output logic [63:0] m, output logic err,
                         output int lat);
        bus_if.icode_i = ic;
        bus_if.vala_i  = a;
        bus_if.vale_i  = e;
        bus_if.valp_i  = p;
        bus_if.start_i = 1'b1;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        lat = 1;
        while (!bus_if.done_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_if.done_o) begin
            check("done_timeout", 64'd0, 64'd1);
            lat = -1;
        end else begin
            check("busy_at_done", 64'(bus_if.busy_o), 64'd1);
        end
        m   = bus_if.valm_o;
        err = bus_if.dmem_error_o;
        @(posedge clk); #1;
        check("done_one_cycle", 64'(bus_if.done_o), 64'd0);
    endtask

    task automatic run_checked(string name, logic [3:0] ic, logic [63:0] a, logic [63:0] e,
                               logic [63:0] p);
        logic [63:0] m, em;
        logic        er, eer, chk;
        int          lat, elat;
        model(ic, a, e, p, em, eer, elat, chk);
        do_op(ic, a, e, p, m, er, lat);
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_err"}, 64'(er), 64'(eer));
        if (chk) check({name, "_valm"}, m, em);
    endtask

    initial begin
        logic [63:0] m, em, old_q, new_q;
        logic        er, eer, chk;
        int          lat, elat, nd;
        logic [63:0] a, e, addr;
        logic [3:0]  ic;

        tests = 0;
        fails = 0;
        bus_if.start_i = 1'b0;
        bus_if.icode_i = 4'h0;
        bus_if.vala_i  = 64'd0;
        bus_if.vale_i  = 64'd0;
        bus_if.valp_i  = 64'd0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus_if.busy_o), 64'd0);
        check("rst_done", 64'(bus_if.done_o), 64'd0);
        check("rst_valm", bus_if.valm_o, 64'd0);
        check("rst_err",  64'(bus_if.dmem_error_o), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Give the low 256 bytes known contents so later reads are predictable.
        for (int i = 0; i < 32; i++) begin
            run_checked("init", 4'h4, {$urandom, $urandom}, 64'(i * 8), 64'd0);
        end

        vecs.push_back(mk("rmmovq",    4'h4, 64'h1122334455667788, 64'h10, 64'h0, 64'h0, 1'b0, 9, 1'b0));
        vecs.push_back(mk("mrmovq",    4'h5, 64'h0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 9, 1'b1));
        vecs.push_back(mk("popq",      4'hB, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 1'b0, 9, 1'b1));
        vecs.push_back(mk("call",      4'h8, 64'h0, 64'h20, 64'h42, 64'h0, 1'b0, 9, 1'b0));
        vecs.push_back(mk("ret",       4'h9, 64'h20, 64'h0, 64'h0, 64'h42, 1'b0, 9, 1'b1));
        vecs.push_back(mk("flt_m7",    4'h5, 64'h0, 64'(DMEM_BYTES - 7), 64'h0, 64'h0, 1'b1, 1, 1'b1));
        vecs.push_back(mk("flt_wrap",  4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1, 1, 1'b1));
        vecs.push_back(mk("bnd_wr",    4'hA, 64'hDEADBEEFCAFEF00D, 64'(DMEM_BYTES - 8), 64'h0, 64'h0, 1'b0, 9, 1'b0));
        vecs.push_back(mk("bnd_rd",    4'h5, 64'h0, 64'(DMEM_BYTES - 8), 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9, 1'b1));
        vecs.push_back(mk("opq",       4'h6, 64'h5, 64'h7, 64'h9, 64'h0, 1'b0, 1, 1'b1));
        vecs.push_back(mk("flt_wr",    4'h4, 64'h0, 64'(DMEM_BYTES - 7), 64'h0, 64'h0, 1'b1, 1, 1'b1));
        vecs.push_back(mk("bnd_keep",  4'h5, 64'h0, 64'(DMEM_BYTES - 8), 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9, 1'b1));

        foreach (vecs[k]) begin
            model(vecs[k].icode, vecs[k].vala, vecs[k].vale, vecs[k].valp, em, eer, elat, chk);
            do_op(vecs[k].icode, vecs[k].vala, vecs[k].vale, vecs[k].valp, m, er, lat);
            check({vecs[k].name, "_lat"}, 64'(lat), 64'(vecs[k].exp_lat));
            check({vecs[k].name, "_err"}, 64'(er), 64'(vecs[k].exp_err));
            if (vecs[k].chk_valm) check({vecs[k].name, "_valm"}, m, vecs[k].exp_valm);
        end

        // Starts while busy and in the DONE cycle must be dropped.
        bus_if.icode_i = 4'h5; bus_if.vale_i = 64'h10; bus_if.vala_i = 64'h0;
        bus_if.start_i = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        m  = 64'd0;
        for (int c = 0; c < 14; c++) begin
            if (bus_if.done_o) begin
                nd++;
                m = bus_if.valm_o;
                bus_if.icode_i = 4'h4; bus_if.vale_i = 64'h10; bus_if.vala_i = 64'h0;
                bus_if.start_i = 1'b1;
            end else if (c < 2) begin
                bus_if.icode_i = 4'h4; bus_if.vale_i = 64'h10; bus_if.vala_i = 64'h0;
                bus_if.start_i = 1'b1;
            end else begin
                bus_if.start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus_if.start_i = 1'b0;
        check("hs_done_count", 64'(nd), 64'd1);
        check("hs_valm", m, 64'h1122334455667788);
        check("hs_idle_after", 64'(bus_if.busy_o), 64'd0);
        run_checked("hs_unchanged", 4'h5, 64'h0, 64'h10, 64'h0);

        // Reset three bytes into a write: those bytes land, the rest keep old data.
        old_q = 64'd0;
        for (int i = 0; i < 8; i++) old_q[8*i +: 8] = ref_mem[8'h30 + i];
        new_q = 64'hA5A5_A5A5_A5C3_B2A1;
        bus_if.icode_i = 4'h4; bus_if.vala_i = new_q; bus_if.vale_i = 64'h30;
        bus_if.start_i = 1'b1;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(bus_if.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus_if.busy_o), 64'd0);
        check("mid_rst_done", 64'(bus_if.done_o), 64'd0);
        check("mid_rst_valm", bus_if.valm_o, 64'd0);
        check("mid_rst_err",  64'(bus_if.dmem_error_o), 64'd0);
        for (int i = 0; i < 3; i++) ref_mem[8'h30 + i] = new_q[8*i +: 8];
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'h5, 64'h0, 64'h30, 64'h0, m, er, lat);
        check("abort_valm", m, {old_q[63:24], new_q[23:0]});
        check("abort_err", 64'(er), 64'd0);

        // Randomized mix against the byte-array model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: ic = 4'h4;
                1: ic = 4'h5;
                2: ic = 4'h8;
                3: ic = 4'h9;
                4: ic = 4'hA;
                5: ic = 4'hB;
                6: ic = 4'h6;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 9))
                0: addr = 64'(DMEM_BYTES - 7 + $urandom_range(0, 64));
                1: addr = {$urandom | 32'h1, $urandom};
                default: addr = 64'($urandom_range(0, 248));
            endcase
            a = {$urandom, $urandom};
            e = {$urandom, $urandom};
            if (ic == 4'h9 || ic == 4'hB) a = addr;
            else e = addr;
            run_checked("rand", ic, a, e, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
